// File: rtl/keccak_pkg.sv
// Shared Keccak constants and the absorb_loader state type.
package keccak_pkg;
  localparam int w            = 64;
  localparam int w_bit_width  = $clog2(w);
  localparam int w_byte_width = $clog2(8);

  localparam int RATE_SHAKE128 = 1344;
  localparam int RATE_SHAKE256 = 1088;

  localparam logic [1:0] SHAKE256_MODE_VEC = 2'b01;

  localparam logic [7:0] SHAKE_PAD_BYTE = 8'h1F;
  localparam logic [7:0] SHA3_PAD_BYTE  = 8'h06;
  localparam logic [7:0] PAD_FINAL_BYTE = 8'h80;

  typedef enum logic [1:0] {IDLE, LOAD, PAD, HOLD} loader_state_t;
endpackage

// File: rtl/absorb_loader_if.sv
// Message-in / block-out bundle for absorb_loader; master drives the loader, slave is the loader.
// sha3_sel exists only when ABSORB_SHA3_PAD_EN is defined.
interface absorb_loader_if
  import keccak_pkg::*;
#(
  parameter int WIDTH    = w,
  parameter int MAX_RATE = RATE_SHAKE128
) ();
  logic                start;
  logic [1:0]          operation_mode;
  logic [31:0]         input_size;
`ifdef ABSORB_SHA3_PAD_EN
  logic                sha3_sel;
`endif
  logic [WIDTH-1:0]    data_in;
  logic                data_in_valid;
  logic                data_in_ready;
  logic [MAX_RATE-1:0] block_out;
  logic                block_valid;
  logic                block_ready;
  logic                last_input_block;
  logic                busy;

  modport master (
`ifdef ABSORB_SHA3_PAD_EN
    output sha3_sel,
`endif
    output start, operation_mode, input_size, data_in, data_in_valid, block_ready,
    input  data_in_ready, block_out, block_valid, last_input_block, busy
  );

  modport slave (
`ifdef ABSORB_SHA3_PAD_EN
    input  sha3_sel,
`endif
    input  start, operation_mode, input_size, data_in, data_in_valid, block_ready,
    output data_in_ready, block_out, block_valid, last_input_block, busy
  );
endinterface

// File: rtl/sipo_buffer.sv
// Serial-in parallel-out word buffer: indexed word write with byte mask, synchronous clear, flat output.
module sipo_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 21
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_idx,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [WIDTH/8-1:0]         wr_mask,
  output logic [WIDTH*DEPTH-1:0]     data
);
  // NOTE: this storage is reset (not left undefined) because its contents are a visible output
  // and unmasked bytes of a partial word must read as zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < WIDTH / 8; b++) begin
        if (wr_mask[b]) data[int'(wr_idx) * WIDTH + b * 8 +: 8] <= wr_data[b * 8 +: 8];
      end
    end
  end
endmodule

// File: rtl/absorb_loader.sv
// Absorb-side loader: packs w-bit message words into rate-sized blocks and applies SHAKE padding.
// Optional ABSORB_SHA3_PAD_EN adds sha3_sel to switch the domain byte to SHA-3 (0x06).
module absorb_loader
  import keccak_pkg::*;
#(
  parameter int WIDTH    = w,
  parameter int MAX_RATE = RATE_SHAKE128,
  parameter int DEPTH    = MAX_RATE / WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  absorb_loader_if.slave bus
);
  localparam int WORD_BYTES = WIDTH / 8;
  localparam int IDX_W      = $clog2(DEPTH);
  localparam int CNT_W      = $clog2(DEPTH + 1);
  localparam int BYTE_W     = $clog2(MAX_RATE / 8 + 1);
  localparam int TAKE_W     = $clog2(WORD_BYTES + 1);

  loader_state_t       state, next_state;
  logic                mode_256, last;
  logic [31:0]         remaining, rem_after;
  logic [CNT_W-1:0]    word_cnt, rate_words;
  logic [BYTE_W-1:0]   fill_bytes, rate_bytes;
  logic [TAKE_W-1:0]   take_bytes;
  logic [WORD_BYTES-1:0] byte_mask;
  logic [7:0]          domain_byte;
  logic                load_ready, accept, block_full, buf_clear;
  logic [MAX_RATE-1:0] buf_data, pad_vec;

  assign rate_words = mode_256 ? CNT_W'(RATE_SHAKE256 / WIDTH) : CNT_W'(DEPTH);
  assign rate_bytes = mode_256 ? BYTE_W'(RATE_SHAKE256 / 8) : BYTE_W'(MAX_RATE / 8);

  assign load_ready = (state == LOAD) && (remaining != '0);
  assign accept     = bus.data_in_valid && load_ready;
  assign buf_clear  = ((state == IDLE) && bus.start) || ((state == HOLD) && bus.block_ready);

  // A final partial word contributes only remaining[w_bit_width-1:w_byte_width] bytes.
  always_comb begin
    if (remaining >= 32'(WIDTH)) take_bytes = TAKE_W'(WORD_BYTES);
    else                         take_bytes = TAKE_W'(remaining[w_bit_width-1:w_byte_width]);
    for (int b = 0; b < WORD_BYTES; b++) byte_mask[b] = (TAKE_W'(b) < take_bytes);
  end

  assign rem_after  = remaining - (32'(take_bytes) << 3);
  // Full means every byte of the rate is message data; a partial last word still gets padded in place.
  assign block_full = (word_cnt + CNT_W'(1) == rate_words) && (take_bytes == TAKE_W'(WORD_BYTES));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: next_state is defaulted first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (bus.start) next_state = (bus.input_size[31:3] == '0) ? PAD : LOAD;
      LOAD: if (accept) begin
        if (block_full)             next_state = HOLD;
        else if (rem_after == '0)   next_state = PAD;
      end
      PAD:  next_state = HOLD;
      HOLD: if (bus.block_ready) begin
        if (last)                   next_state = IDLE;
        else if (remaining == '0)   next_state = PAD;
        else                        next_state = LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.data_in_ready    = load_ready;
    bus.block_valid      = (state == HOLD);
    bus.last_input_block = (state == HOLD) && last;
    bus.busy             = (state != IDLE);
  end

`ifdef ABSORB_SHA3_PAD_EN
  logic sha3;
  assign domain_byte = sha3 ? SHA3_PAD_BYTE : SHAKE_PAD_BYTE;
`else
  assign domain_byte = SHAKE_PAD_BYTE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_256   <= 1'b0;
      remaining  <= '0;
      word_cnt   <= '0;
      fill_bytes <= '0;
      last       <= 1'b0;
`ifdef ABSORB_SHA3_PAD_EN
      sha3       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          mode_256   <= (bus.operation_mode == SHAKE256_MODE_VEC);
          remaining  <= bus.input_size & ~32'h7;
          word_cnt   <= '0;
          fill_bytes <= '0;
          last       <= 1'b0;
`ifdef ABSORB_SHA3_PAD_EN
          sha3       <= bus.sha3_sel;
`endif
        end
        LOAD: if (accept) begin
          word_cnt   <= word_cnt + CNT_W'(1);
          remaining  <= rem_after;
          fill_bytes <= fill_bytes + BYTE_W'(take_bytes);
        end
        PAD:  last <= 1'b1;
        HOLD: if (bus.block_ready) begin
          word_cnt   <= '0;
          fill_bytes <= '0;
          last       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Padding is overlaid on the buffer once the block is marked last, so HOLD sees a stable padded block.
  always_comb begin
    pad_vec = '0;
    if (last) begin
      pad_vec[int'(fill_bytes) * 8 +: 8]         = domain_byte;
      pad_vec[(int'(rate_bytes) - 1) * 8 +: 8]   = pad_vec[(int'(rate_bytes) - 1) * 8 +: 8] | PAD_FINAL_BYTE;
    end
  end

  assign bus.block_out = buf_data | pad_vec;

  sipo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clear   (buf_clear),
    .wr_en   (accept),
    .wr_idx  (word_cnt[IDX_W-1:0]),
    .wr_data (bus.data_in),
    .wr_mask (byte_mask),
    .data    (buf_data)
  );
endmodule

// File: tb/tb_absorb_loader.sv
// Self-checking bench for absorb_loader: random messages checked against a byte-level SHAKE padding model.
module tb_absorb_loader;
  import keccak_pkg::*;

  localparam int MAXR = RATE_SHAKE128;
  localparam int NW   = MAXR / 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  absorb_loader_if #(.WIDTH(64), .MAX_RATE(MAXR)) bus ();
  absorb_loader #(.WIDTH(64), .MAX_RATE(MAXR)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]      msg[$];
  logic [63:0]     words[$];
  logic [MAXR-1:0] exp_blk[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_block(input string tag, input int b);
    for (int k = 0; k < NW; k++)
      check($sformatf("%s blk%0d w%0d", tag, b, k), bus.block_out[k * 64 +: 64], exp_blk[b][k * 64 +: 64]);
    check($sformatf("%s blk%0d last", tag, b), 64'(bus.last_input_block), 64'(b == exp_blk.size() - 1));
  endtask

  // Reference: message bytes, domain byte at msg_len, 0x80 on the final byte of the padded length.
  function automatic void model(input bit m256, input bit sha3);
    int rb   = m256 ? 136 : 168;
    int n    = msg.size();
    int nblk = n / rb + 1;
    bit [7:0] padded[];
    logic [MAXR-1:0] vec;
    padded = new[nblk * rb];
    foreach (msg[i]) padded[i] = msg[i];
    padded[n]            = padded[n] | (sha3 ? 8'h06 : 8'h1F);
    padded[nblk * rb - 1] = padded[nblk * rb - 1] | 8'h80;
    exp_blk.delete();
    for (int b = 0; b < nblk; b++) begin
      vec = '0;
      for (int j = 0; j < rb; j++) vec[j * 8 +: 8] = padded[b * rb + j];
      exp_blk.push_back(vec);
    end
  endfunction

  task automatic run_msg(input string name, input bit m256, input int nbytes, input int hold0,
                         input bit fixed, input logic [63:0] fixed_word);
    bit sha3 = 1'b0;
    int rb   = m256 ? 136 : 168;
    logic [63:0] wd;
`ifdef ABSORB_SHA3_PAD_EN
    sha3 = 1'($urandom_range(1));
`endif
    msg.delete();
    for (int i = 0; i < nbytes; i++) msg.push_back(8'($urandom));
    if (fixed) for (int i = 0; i < 8 && i < nbytes; i++) msg[i] = fixed_word[i * 8 +: 8];
    model(m256, sha3);
    words.delete();
    for (int i = 0; i < (nbytes + 7) / 8; i++) begin
      for (int b = 0; b < 8; b++) wd[b * 8 +: 8] = (i * 8 + b < nbytes) ? msg[i * 8 + b] : 8'($urandom);
      words.push_back(wd);
    end

    @(negedge clk);
    bus.start          = 1'b1;
    bus.operation_mode = m256 ? SHAKE256_MODE_VEC : 2'(SHAKE256_MODE_VEC + 2'($urandom_range(1, 3)));
    bus.input_size     = 32'(nbytes * 8) | 32'($urandom_range(7));
`ifdef ABSORB_SHA3_PAD_EN
    bus.sha3_sel       = sha3;
`endif
    @(negedge clk);
    bus.start      = 1'b0;
    bus.input_size = $urandom;
    check({name, " busy_rise"}, 64'(bus.busy), 64'd1);

    fork
      begin : feeder
        int wi = 0;
        int guard = 0;
        while (wi < words.size() && guard < 4000) begin
          @(negedge clk);
          guard++;
          if ($urandom_range(3) == 0) bus.data_in_valid = 1'b0;
          else begin
            bus.data_in_valid = 1'b1;
            bus.data_in       = words[wi];
            if (bus.data_in_ready) wi++;
          end
        end
        if (words.size() > 0) begin
          check({name, " words_accepted"}, 64'(wi), 64'(words.size()));
          @(negedge clk);
          bus.data_in_valid = 1'b0;
          check({name, " ready_after_last"}, 64'(bus.data_in_ready), 64'd0);
          if (nbytes % rb == 0) check({name, " lat_full"}, 64'(bus.block_valid), 64'd1);
          else begin
            check({name, " lat_pad0"}, 64'(bus.block_valid), 64'd0);
            @(negedge clk);
            check({name, " lat_pad1"}, 64'(bus.block_valid), 64'd1);
          end
        end
      end
      begin : receiver
        for (int b = 0; b < exp_blk.size(); b++) begin
          int guard = 0;
          int d;
          while (!bus.block_valid && guard < 4000) begin
            @(negedge clk);
            guard++;
          end
          check($sformatf("%s blk%0d valid", name, b), 64'(bus.block_valid), 64'd1);
          if (!bus.block_valid) break;
          check_block(name, b);
          d = (b == 0 && hold0 > 0) ? hold0 : int'($urandom_range(2));
          for (int c = 0; c < d; c++) begin
            if (c == 0) begin
              bus.start      = 1'b1;
              bus.input_size = 32'd8;
            end
            @(negedge clk);
            bus.start = 1'b0;
            check($sformatf("%s hold%0d valid", name, c), 64'(bus.block_valid), 64'd1);
            check($sformatf("%s hold%0d ready", name, c), 64'(bus.data_in_ready), 64'd0);
            if (hold0 > 0 && b == 0) check_block($sformatf("%s hold%0d", name, c), b);
          end
          bus.block_ready = 1'b1;
          @(negedge clk);
          bus.block_ready = 1'b0;
        end
      end
    join
    check({name, " busy_fall"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.operation_mode = 2'b00;
    bus.input_size = '0;
`ifdef ABSORB_SHA3_PAD_EN
    bus.sha3_sel = 1'b0;
`endif
    bus.data_in = '0;
    bus.data_in_valid = 1'b0;
    bus.block_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset valid", 64'(bus.block_valid), 64'd0);
    check("reset last", 64'(bus.last_input_block), 64'd0);
    check("reset ready", 64'(bus.data_in_ready), 64'd0);
    for (int k = 0; k < NW; k++) check($sformatf("reset w%0d", k), bus.block_out[k * 64 +: 64], 64'd0);

    run_msg("empty128", 1'b0, 0,    0,  1'b0, 64'd0);
    run_msg("one_word", 1'b0, 8,    0,  1'b1, 64'h0123456789ABCDEF);
    run_msg("exact256", 1'b1, 136,  0,  1'b0, 64'd0);
    run_msg("b167_128", 1'b0, 167,  0,  1'b0, 64'd0);
    run_msg("hold128",  1'b0, 200,  10, 1'b0, 64'd0);
    run_msg("exact128", 1'b0, 168,  0,  1'b0, 64'd0);
    run_msg("b135_256", 1'b1, 135,  0,  1'b0, 64'd0);
    run_msg("b137_256", 1'b1, 137,  0,  1'b0, 64'd0);
    run_msg("b169_128", 1'b0, 169,  0,  1'b0, 64'd0);
    run_msg("two_256",  1'b1, 272,  0,  1'b0, 64'd0);

    // Abort a message after five words; the loader must return to a quiet, empty state.
    @(negedge clk);
    bus.start = 1'b1;
    bus.operation_mode = 2'(SHAKE256_MODE_VEC + 2'd1);
    bus.input_size = 32'd320;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.data_in_valid = 1'b1;
      bus.data_in = {$urandom, $urandom};
      @(negedge clk);
    end
    bus.data_in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort valid", 64'(bus.block_valid), 64'd0);
    check("abort last", 64'(bus.last_input_block), 64'd0);
    check("abort ready", 64'(bus.data_in_ready), 64'd0);
    for (int k = 0; k < NW; k++) check($sformatf("abort w%0d", k), bus.block_out[k * 64 +: 64], 64'd0);
    run_msg("after_abort", 1'b0, 1, 0, 1'b0, 64'd0);

    for (int t = 0; t < 6; t++)
      run_msg($sformatf("rand%0d", t), 1'($urandom_range(1)), int'($urandom_range(400)),
              0, 1'b0, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/absorb_loader.md
Name: absorb_loader

Overview:
- Input-side counterpart of the squeeze/dump datapath.
- Accepts the message as a stream of w-bit words over a valid/ready handshake and assembles them into rate-sized blocks for the Keccak absorb stage.
- Applies SHAKE padding on the final block and presents each block with a valid/ready handshake plus a last-block flag.
- Sits between the external data input and the state XOR/permutation stage.

Parameters:
WIDTH, w (64), input word width in bits.
MAX_RATE, RATE_SHAKE128 (1344), block register width in bits.
DEPTH, MAX_RATE/WIDTH (21), block capacity in words.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
start  in  1  one-cycle pulse; latches operation_mode and input_size. Ignored unless IDLE.
operation_mode  in  2  SHAKE256_MODE_VEC selects rate 1088 (17 words); any other value selects 1344 (21 words).
input_size  in  32  message length in bits, byte multiple; bits [2:0] ignored.
data_in  in  WIDTH  message word, little-endian bytes.
data_in_valid  in  1  data_in is valid.
data_in_ready  out  1  loader accepts a word this cycle.
block_out  out  MAX_RATE  assembled block; word k at bits [k*WIDTH +: WIDTH].
block_valid  out  1  block_out is complete.
block_ready  in  1  downstream consumes block.
last_input_block  out  1  qualifies block_valid; final padded block.
busy  out  1  high from start until last block is consumed.

Behaviour:
- Reset: state IDLE; all outputs 0; buffer, word counter and remaining-bit counter cleared. rst mid-operation aborts the message, with no partial block emitted.
- Fixed rate configuration: rate_words = 17 or 21; rate_bytes = 136 or 168. In SHAKE256 mode, block_out bits [1343:1088] are always 0.
- IDLE: data_in_ready=0.
  - start: remaining=input_size, word_cnt=0, buffer cleared.
  - Next state is LOAD, or PAD if input_size=0.
- LOAD:
  - data_in_ready = (remaining>0).
  - Accept (data_in_valid & data_in_ready): write word at slot word_cnt, word_cnt++, remaining -= min(WIDTH, remaining).
  - Partial final word: keep low remaining[w_bit_width-1:3] bytes; zero the rest.
  - After accept, block full: go to HOLD with last=0. This applies even if remaining became 0, because an exact-multiple message needs an extra padding-only block.
  - After accept, remaining=0 and block not full: go to PAD.
  - At most one word per cycle; no gaps are inserted by the loader.
- PAD (1 cycle, data_in_ready=0):
  - OR 0x1F into byte (message_bytes mod rate_bytes).
  - OR 0x80 into byte rate_bytes-1. If both land on the same byte, the result is 0x9F.
  - Go to HOLD with last=1.
- HOLD:
  - block_valid=1, last_input_block=last, data_in_ready=0, block_out stable.
  - On block_ready, last=1: go to IDLE; busy falls next cycle.
  - On block_ready, last=0: clear buffer, word_cnt=0, go to LOAD, or PAD if remaining=0.
- Latency: block_valid rises 1 cycle after the accept that fills a block, or 2 cycles after the final accept of a message (via PAD).
- Simultaneous start with any state other than IDLE: start ignored.
- data_in_valid outside LOAD: ignored.

Optional Feature:
- Macro ABSORB_SHA3_PAD_EN.
- When defined: adds input port sha3_sel (1 bit, latched at start). When sha3_sel=1, PAD uses domain byte 0x06 instead of 0x1F; a coincident final byte becomes 0x86.
- When undefined: the port is absent and padding is always 0x1F.

Decomposition:
- keccak_pkg holds w, w_bit_width, w_byte_width, RATE_SHAKE128, RATE_SHAKE256 and SHAKE256_MODE_VEC.
- Add to keccak_pkg: SHAKE_PAD_BYTE=8'h1F, SHA3_PAD_BYTE=8'h06, PAD_FINAL_BYTE=8'h80, and enum loader_state_t {IDLE, LOAD, PAD, HOLD}.
- Sub-module sipo_buffer, the input-side peer of piso_buffer: WIDTH/DEPTH params, indexed word write with byte mask, synchronous clear, flat parallel output.
- FSM, counters and padding OR-in stay in absorb_loader.

Test Plan:
1. SHAKE128, input_size=0 -> one block with byte0=0x1F, byte167=0x80, all else 0; last_input_block=1.
2. SHAKE128, input_size=64, word 0x0123456789ABCDEF -> word0 equals that value, byte8=0x1F, byte167=0x80, last=1.
3. SHAKE256, input_size=1088 (17 words) -> block1 holds the 17 words with last=0 and bits above 1087 zero; block2 has byte0=0x1F, byte135=0x80, last=1.
4. SHAKE128, input_size=1336 -> word20 keeps 7 bytes and byte167=0x9F; data_in_ready is deasserted after the 21st accept.
5. block_ready held 0 for 10 cycles in HOLD -> block_valid stays 1, block_out is unchanged, data_in_ready=0; consumption proceeds normally on release.
6. rst pulsed mid-LOAD after 5 words -> next cycle all outputs 0; new start with input_size=8 yields byte0=data, byte1=0x1F.
